// File: rtl/encoder_arbiter_16.sv
// encoder_arbiter_16: round-robin arbiter for 16 requesters.
// It issues a registered grant, shown both one-hot and as a 4-bit index.
// The grant is held until the owner drops its request.
// Optional watchdog: define ENCODER_ARB_TIMEOUT_EN to force-release a grant
// that has been held for MAX_HOLD cycles.
module encoder_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] req,
    output logic        gnt_vld,
    output logic [3:0]  gnt_idx,
    output logic [15:0] gnt_onehot,
    output logic        timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 1023) begin : g_bad_max_hold
        $error("encoder_arbiter_16: MAX_HOLD must be in 2..1023");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] oh_q, oh_d;
    logic        to_q, to_d;
    logic        new_grant;
    logic        force_rel;
    logic [15:0] masked;
    logic [3:0]  pick;

    // First set bit of v, searching p, p+1, ... modulo 16.
    function automatic logic [3:0] rr_pick(input logic [15:0] v, input logic [3:0] p);
        logic [3:0] k;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            k = p + 4'(i);
            if (!found && v[k]) begin
                found   = 1'b1;
                rr_pick = k;
            end
        end
    endfunction

    // Next-state: issue, hold, or release (with same-cycle re-arbitration).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        oh_d      = oh_q;
        to_d      = 1'b0;
        new_grant = 1'b0;
        masked    = '0;
        pick      = '0;
        case (state_q)
            IDLE: begin
                if (en && (req != '0)) begin
                    pick      = rr_pick(req, ptr_q);
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                // force_rel only fires while the owner still requests, so a
                // normal release at the same edge never raises timeout.
                if (!req[idx_q] || force_rel) begin
                    ptr_d  = idx_q + 4'd1;
                    to_d   = force_rel;
                    masked = req & ~(16'b1 << idx_q);
                    pick   = rr_pick(masked, ptr_d);
                    if (en && (masked != '0)) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        oh_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            state_d = GRANT;
            idx_d   = pick;
            oh_d    = 16'b1 << pick;
        end
    end

`ifdef ENCODER_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Watchdog trips once the current owner has been visible MAX_HOLD cycles.
    always_comb begin
        force_rel = (state_q == GRANT) && (cnt_q == CNT_W'(MAX_HOLD)) && req[idx_q];
    end

    // Hold counter: 1 on a fresh grant, counts while held, 0 when idle.
    always_comb begin
        cnt_d = '0;
        if (new_grant) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == GRANT && state_d == GRANT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            oh_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            to_q    <= to_d;
        end
    end

    assign gnt_vld    = (state_q == GRANT);
    assign gnt_idx    = idx_q;
    assign gnt_onehot = oh_q;
    assign timeout    = to_q;

endmodule

// File: tb/tb_encoder_arbiter_16.sv
// Directed bench for encoder_arbiter_16. It applies a vector table and then
// runs hand sequences for async reset and for the watchdog/hold behaviour.
module tb_encoder_arbiter_16;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] req;
    logic        gnt_vld;
    logic [3:0]  gnt_idx;
    logic [15:0] gnt_onehot;
    logic        timeout;

    int unsigned errors = 0;
    int unsigned checks = 0;

    encoder_arbiter_16 #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .gnt_vld    (gnt_vld),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] req;
        logic        vld;
        logic [3:0]  idx;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic r, logic e, logic [15:0] q, logic v, logic [3:0] i);
        vec_t x;
        x.rst = r; x.en = e; x.req = q; x.vld = v; x.idx = i;
        tbl.push_back(x);
    endfunction

    task automatic chk(string name, logic ev, logic [3:0] ei, logic et);
        logic [15:0] eoh;
        eoh = ev ? (16'b1 << ei) : 16'h0000;
        checks++;
        if (gnt_vld !== ev || gnt_idx !== ei || gnt_onehot !== eoh || timeout !== et) begin
            errors++;
            $display("FAIL %s: got vld=%0b idx=%0d oh=%h to=%0b, expected vld=%0b idx=%0d oh=%h to=%0b",
                     name, gnt_vld, gnt_idx, gnt_onehot, timeout, ev, ei, eoh, et);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic step(logic e, logic [15:0] q);
        @(negedge clk);
        en  = e;
        req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        #12;
        chk("reset_state", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;

        // Round-robin wrap 0 -> 15 -> 0, then single request idx 4.
        add(1, 1, 16'h8001, 1, 0);
        add(0, 1, 16'h8000, 1, 15);
        add(0, 1, 16'h8001, 1, 15);
        add(0, 1, 16'h0001, 1, 0);
        add(0, 1, 16'h0001, 1, 0);
        add(0, 1, 16'h0000, 0, 0);
        add(0, 1, 16'h0010, 1, 4);
        add(0, 1, 16'h0000, 0, 0);
        // Enable gating.
        add(1, 0, 16'hFFFF, 0, 0);
        add(0, 0, 16'hFFFF, 0, 0);
        add(0, 0, 16'hFFFF, 0, 0);
        add(0, 0, 16'hFFFF, 0, 0);
        add(0, 0, 16'hFFFF, 0, 0);
        add(0, 1, 16'hFFFF, 1, 0);
        add(0, 0, 16'hFFFF, 1, 0);
        add(0, 0, 16'hFFFE, 0, 0);
        add(0, 0, 16'hFFFE, 0, 0);
        add(0, 1, 16'hFFFE, 1, 1);
        // Simultaneous release and request, then a second release to idx 2.
        add(1, 1, 16'h0008, 1, 3);
        add(0, 1, 16'h0024, 1, 5);
        add(0, 1, 16'h0020, 1, 5);
        add(0, 1, 16'h0004, 1, 2);
        add(0, 1, 16'h0000, 0, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) pulse_reset();
            step(tbl[i].en, tbl[i].req);
            chk($sformatf("vec%0d", i), tbl[i].vld, tbl[i].idx, 1'b0);
        end

        // Async reset mid-grant with ptr moved to 8, then ptr must restart at 0.
        pulse_reset();
        step(1'b1, 16'h0080);
        chk("rst_seq_g7a", 1'b1, 4'd7, 1'b0);
        step(1'b1, 16'h0000);
        chk("rst_seq_idle", 1'b0, 4'd0, 1'b0);
        step(1'b1, 16'h0080);
        chk("rst_seq_g7b", 1'b1, 4'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h0180);
        chk("rst_ptr_zero", 1'b1, 4'd7, 1'b0);

        // Watchdog / indefinite hold with req 0x0004 held.
        pulse_reset();
`ifdef ENCODER_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 16'h0004);
            chk($sformatf("wd_hold%0d", k), 1'b1, 4'd2, 1'b0);
        end
        step(1'b1, 16'h0004);
        chk("wd_timeout", 1'b0, 4'd0, 1'b1);
        step(1'b1, 16'h0004);
        chk("wd_regrant", 1'b1, 4'd2, 1'b0);
        step(1'b1, 16'h0004);
        chk("wd_regrant_hold", 1'b1, 4'd2, 1'b0);
`else
        for (int k = 1; k <= 110; k++) begin
            step(1'b1, 16'h0004);
            chk($sformatf("hold%0d", k), 1'b1, 4'd2, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_arbiter_16.md
# encoder_arbiter_16

Round-robin arbiter that shares one downstream resource among 16 requesters and presents the winner both as a one-hot grant and as a 4-bit encoded index, the same 16-to-4 encoding our encoder block produces. It sits between the requester bank and the shared datapath. Grants are registered and held until the owner releases. An optional watchdog revokes grants that are held too long.

## Interface
- `MAX_HOLD`, default 64: maximum cycles a grant may be held when the watchdog is compiled in. Legal range 2..1023.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `en`  in  1: arbitration enable. When 0, no new grant is issued and an existing grant is unaffected.
- `req`  in  16: request vector; bit k is requester k. The requester holds its bit high for the whole ownership period.
- `gnt_vld`  out  1: a grant is active.
- `gnt_idx`  out  4: encoded index of the owner. Equals 0 when `gnt_vld`=0.
- `gnt_onehot`  out  16: one-hot owner, equal to 1<<`gnt_idx` when valid, else 0.
- `timeout`  out  1: one-cycle pulse on a watchdog-forced release.

## Operation
- Two states: IDLE (no owner) and GRANT (owner = `gnt_idx`).
- Round-robin pointer `ptr` (4 bits) gives the highest-priority index. Search order is ptr, ptr+1, …, 15, 0, …, ptr-1, modulo 16.
- IDLE: if `en`=1 and `req`≠0, pick the first set bit in search order and go to GRANT. Otherwise stay in IDLE.
- GRANT, release: when `req[gnt_idx]` is sampled 0, set ptr ← gnt_idx+1 (15 wraps to 0).
  - In the same cycle, arbitrate over `req` with the releasing bit masked.
  - If `en`=1 and the masked vector is nonzero, go directly to GRANT for the new winner (no idle gap). Otherwise go to IDLE.
- GRANT, owner still requesting: hold. Other requests have no effect.
- Requests for bits other than the owner may toggle freely. Only the sampled value at arbitration counts.
- `en` falling during GRANT does not revoke the grant. The release path still applies; it only suppresses the follow-on grant.

## Timing
- Reset (async assert, sync deassert by the surrounding design) gives: state IDLE, ptr=0, `gnt_vld`=0, `gnt_idx`=0, `gnt_onehot`=0, `timeout`=0, hold counter 0.
- Reset asserted mid-grant drops all outputs immediately, without waiting for a clock edge.
- Grant latency: a request sampled at edge N in IDLE makes `gnt_*` valid after edge N (one-cycle registered latency).
- Release latency: `req[owner]`=0 sampled at edge N makes `gnt_*` change after edge N, either to 0 or to the next owner.
- All outputs are registered. There is no combinational path from `req` to the outputs.
- `gnt_idx`, `gnt_onehot` and `gnt_vld` always update on the same edge.

## Configuration
- Macro: `ENCODER_ARB_TIMEOUT_EN`.
- When defined:
  - A hold counter of width clog2(MAX_HOLD+1) loads 1 on each new grant and increments while the same owner holds.
  - At an edge where count==MAX_HOLD and the owner still requests, force a release exactly as above (ptr advances, the owner's bit is masked for that arbitration) and pulse `timeout`=1 for one cycle.
  - A grant is therefore visible for at most MAX_HOLD cycles.
  - A normal release at the same edge counts as a normal release: no timeout pulse.
- When undefined: no counter logic exists, `timeout` is tied to 0, and grants are held indefinitely.

## Test plan
- Single request: after reset, `en`=1, `req`=16'h0010 → next cycle `gnt_vld`=1, `gnt_idx`=4, `gnt_onehot`=16'h0010. Then `req`=0 → next cycle all outputs are 0.
- Round-robin wrap: `req`=16'h8001 held; each owner drops its bit for one cycle, then re-raises it.
  - Required grant sequence is idx 0, then 15 with no gap, then 0 (ptr wraps 15→0).
- Enable gating: `en`=0, `req`=16'hFFFF for 5 cycles → `gnt_vld` stays 0. Then `en`=1 → next cycle `gnt_idx`=0. Then `en`=0 while granted → grant is held until released, and no follow-on grant is issued.
- Reset mid-operation: grant idx 7 active, `rst_n` pulled low between edges → outputs are 0 immediately. After release with `req`=16'h0180, the grant is idx 7 (ptr back to 0).
- Watchdog (macro defined, MAX_HOLD=4): `req`=16'h0004 held constantly.
  - `gnt_idx`=2 is valid for exactly 4 cycles, then `gnt_vld`=0 with `timeout`=1 for one cycle.
  - Next cycle the grant is idx 2 again.
  - With the macro undefined, the grant is held for 100+ cycles and `timeout` stays 0.
- Simultaneous release and request: owner idx 3 releases on the same edge that requests 2 and 5 are present, with ptr=0 → next owner is idx 5 (ptr=4), with no idle cycle.
